// File: rtl/ifetch_pkg.sv
// +------------------------------------------------------------------+
// | ifetch_pkg : shared types for the instruction-fetch read master  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +------------------------------------------------------------------+
// | fetch_fifo : prefetch buffer with synchronous flush              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves at the same edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_read_master.sv
// +------------------------------------------------------------------+
// | ifetch_read_master : sequential instruction fetch with prefetch  |
// | buffer and redirect; IFETCH_PERF_EN enables perf counters.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ifetch_read_master
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        rreq,
  output logic [31:0] raddr,
  input  logic [31:0] rdata,
  input  logic        data_valid,
  output logic        busy,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_wait_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   raddr_q, raddr_d;
  logic          rreq_q, rreq_d;
  logic          push, pop, flush, slot_free, issue;
  logic [CW-1:0] count, occ_next;
  fetch_entry_t  head, push_entry;
  logic          head_valid;

  // A redirect flushes and suppresses both the push and the pop of its cycle.
  assign flush      = redirect_valid;
  assign pop        = head_valid && out_ready && !redirect_valid;
  assign push       = (state_q == WAIT) && data_valid && !redirect_valid;
  assign occ_next   = flush ? '0 : (count + CW'(push) - CW'(pop));
  assign push_entry = '{inst: rdata, pc: pc_q};

  // pc_q is the address of the outstanding request, or the next one to issue.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rreq_d    = rreq_q;
    raddr_d   = raddr_q;
    slot_free = 1'b0;
    issue     = 1'b0;
    if (redirect_valid) pc_d = redirect_pc & ~32'h3;
    case (state_q)
      IDLE: slot_free = 1'b1;
      WAIT: begin
        if (data_valid) begin
          slot_free = 1'b1;
          if (!redirect_valid) pc_d = pc_q + PC_STEP;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: slot_free = data_valid;
      default: begin
        state_d = IDLE;
        rreq_d  = 1'b0;
      end
    endcase
    if (slot_free) begin
      issue   = (occ_next < CW'(DEPTH));
      state_d = issue ? WAIT : IDLE;
      rreq_d  = issue;
      if (issue) raddr_d = word_addr(pc_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ~32'h3;
      rreq_q  <= 1'b0;
      raddr_q <= word_addr(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rreq_q  <= rreq_d;
      raddr_q <= raddr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign out_valid = head_valid;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign rreq      = rreq_q;
  assign raddr     = raddr_q;
  assign busy      = (state_q != IDLE);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_req_d  = perf_req_q + 32'(issue);
    perf_wait_d = perf_wait_q + 32'(state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_req_q  <= perf_req_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_req_cnt  = perf_req_q;
  assign perf_wait_cnt = perf_wait_q;
`else
  assign perf_req_cnt  = '0;
  assign perf_wait_cnt = '0;
`endif

`ifndef SYNTHESIS
  a_no_dv_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(data_valid && state_q == IDLE))
    else $error("ifetch_read_master: data_valid with no request outstanding");
`endif

endmodule

`default_nettype wire
